// File: rtl/i2s_frame_sequencer_if.sv
// Effect-chain handshake bus: captured pair out with valid/ready, processed pair back with a done strobe.
interface i2s_frame_sequencer_if #(
  parameter int d_width = 24
);
  logic signed [d_width-1:0] fx_l_out;
  logic signed [d_width-1:0] fx_r_out;
  logic                      fx_valid;
  logic                      fx_ready;
  logic signed [d_width-1:0] fx_l_in;
  logic signed [d_width-1:0] fx_r_in;
  logic                      fx_done;

  modport master (
    output fx_l_out, fx_r_out, fx_valid,
    input  fx_ready, fx_l_in, fx_r_in, fx_done
  );

  modport slave (
    input  fx_l_out, fx_r_out, fx_valid,
    output fx_ready, fx_l_in, fx_r_in, fx_done
  );
endinterface

// File: rtl/i2s_frame_sequencer.sv
// Schedules stereo frames between the I2S transceiver and the effect chain: capture on ad_ws,
// offer to fx, hold the processed pair, commit on da_ws. Tracks underrun/overrun with saturating counters.
module i2s_frame_sequencer #(
  parameter int d_width       = 24,
  parameter int cnt_width     = 16,
  parameter bit mute_on_under = 1'b0
) (
  input  logic                      mclk,
  input  logic                      reset_n,
  input  logic                      ad_ws,
  input  logic                      da_ws,
  input  logic signed [d_width-1:0] l_data_rx,
  input  logic signed [d_width-1:0] r_data_rx,
  output logic signed [d_width-1:0] l_data_tx,
  output logic signed [d_width-1:0] r_data_tx,
  input  logic                      bypass,
  input  logic                      mute,
  output logic [cnt_width-1:0]      underrun_cnt,
  output logic [cnt_width-1:0]      overrun_cnt,
  i2s_frame_sequencer_if.master     fx
);

  typedef struct packed {
    logic [d_width-1:0] l;
    logic [d_width-1:0] r;
  } pair_t;

  typedef enum logic [2:0] {IDLE, CAPTURE, OFFER, WAIT_FX, PEND} state_t;

  state_t               state_q;
  logic                 ad_ws_q, da_ws_q;
  logic                 ad_edge_q, da_edge_q;
  pair_t                cap_q, pend_q, tx_q;
  logic                 fx_valid_q;
  logic                 pending_q;
  logic [cnt_width-1:0] under_q, over_q;
  logic                 pend_set;

  // History regs reset high so a low ws at reset release is not taken as a frame start.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      ad_ws_q   <= 1'b1;
      da_ws_q   <= 1'b1;
      ad_edge_q <= 1'b0;
      da_edge_q <= 1'b0;
    end else begin
      ad_ws_q   <= ad_ws;
      da_ws_q   <= da_ws;
      ad_edge_q <= ad_ws_q & ~ad_ws;
      da_edge_q <= da_ws_q & ~da_ws;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      pend_q     <= '0;
      fx_valid_q <= 1'b0;
      over_q     <= '0;
    end else begin
      // A frame arriving while busy is dropped; the in-flight pair keeps going.
      if (ad_edge_q && state_q != IDLE && over_q != '1)
        over_q <= over_q + 1'b1;
      case (state_q)
        IDLE:    if (ad_edge_q) state_q <= CAPTURE;
        CAPTURE: begin
          cap_q <= '{l: l_data_rx, r: r_data_rx};
          if (bypass) begin
            pend_q  <= '{l: l_data_rx, r: r_data_rx};
            state_q <= PEND;
          end else begin
            fx_valid_q <= 1'b1;
            state_q    <= OFFER;
          end
        end
        OFFER: if (fx.fx_ready) begin
          fx_valid_q <= 1'b0;
          state_q    <= WAIT_FX;
        end
        WAIT_FX: if (fx.fx_done) begin
          pend_q  <= '{l: fx.fx_l_in, r: fx.fx_r_in};
          state_q <= PEND;
        end
        PEND:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pend_set = (state_q == PEND);

  // Commit sees the pending flag from before this cycle; a pair landing now stays pending.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      tx_q      <= '0;
      pending_q <= 1'b0;
      under_q   <= '0;
    end else if (da_edge_q) begin
      if (mute) begin
        tx_q <= '0;
      end else if (pending_q) begin
        tx_q <= pend_q;
      end else begin
        if (under_q != '1) under_q <= under_q + 1'b1;
        if (mute_on_under) tx_q <= '0;
      end
      pending_q <= pend_set;
    end else if (pend_set) begin
      pending_q <= 1'b1;
    end
  end

  assign l_data_tx    = tx_q.l;
  assign r_data_tx    = tx_q.r;
  assign underrun_cnt = under_q;
  assign overrun_cnt  = over_q;
  assign fx.fx_l_out  = cap_q.l;
  assign fx.fx_r_out  = cap_q.r;
  assign fx.fx_valid  = fx_valid_q;

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Directed bench: two sequencer instances share stimulus; u0 repeats on underrun (16-bit counters),
// u1 zeroes on underrun with 4-bit counters to reach saturation quickly.
module tb_i2s_frame_sequencer;
  logic        mclk = 1'b0;
  logic        reset_n;
  logic        ad_ws, da_ws, bypass, mute;
  logic [23:0] l_rx, r_rx;
  logic [23:0] l_tx0, r_tx0, l_tx1, r_tx1;
  logic [15:0] und0, ovr0;
  logic [3:0]  und1, ovr1;
  int checks = 0;
  int errors = 0;

  i2s_frame_sequencer_if #(.d_width(24)) fx0 ();
  i2s_frame_sequencer_if #(.d_width(24)) fx1 ();

  assign fx1.fx_ready = fx0.fx_ready;
  assign fx1.fx_l_in  = fx0.fx_l_in;
  assign fx1.fx_r_in  = fx0.fx_r_in;
  assign fx1.fx_done  = fx0.fx_done;

  always #5 mclk = ~mclk;

  i2s_frame_sequencer #(.d_width(24), .cnt_width(16), .mute_on_under(1'b0)) u0 (
    .mclk(mclk), .reset_n(reset_n), .ad_ws(ad_ws), .da_ws(da_ws),
    .l_data_rx(l_rx), .r_data_rx(r_rx), .l_data_tx(l_tx0), .r_data_tx(r_tx0),
    .bypass(bypass), .mute(mute), .underrun_cnt(und0), .overrun_cnt(ovr0), .fx(fx0));

  i2s_frame_sequencer #(.d_width(24), .cnt_width(4), .mute_on_under(1'b1)) u1 (
    .mclk(mclk), .reset_n(reset_n), .ad_ws(ad_ws), .da_ws(da_ws),
    .l_data_rx(l_rx), .r_data_rx(r_rx), .l_data_tx(l_tx1), .r_data_tx(r_tx1),
    .bypass(bypass), .mute(mute), .underrun_cnt(und1), .overrun_cnt(ovr1), .fx(fx1));

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  // Falling ad_ws with rx data held until the FSM has captured it, then ws back high.
  task automatic ad_frame(input logic [23:0] l, input logic [23:0] r);
    l_rx = l; r_rx = r; ad_ws = 1'b0;
    cyc(4);
    ad_ws = 1'b1;
    cyc(2);
  endtask

  task automatic da_fall();
    da_ws = 1'b0;
    cyc(3);
    da_ws = 1'b1;
    cyc(2);
  endtask

  initial begin
    reset_n = 1'b0; ad_ws = 1'b1; da_ws = 1'b1; bypass = 1'b0; mute = 1'b0;
    l_rx = '0; r_rx = '0;
    fx0.fx_ready = 1'b0; fx0.fx_l_in = '0; fx0.fx_r_in = '0; fx0.fx_done = 1'b0;
    cyc(3);
    chk("rst_l_tx", l_tx0, 24'h0);
    chk("rst_fx_valid", {23'b0, fx0.fx_valid}, 24'h0);
    chk("rst_under", {8'b0, und0}, 24'h0);
    chk("rst_over", {8'b0, ovr0}, 24'h0);
    reset_n = 1'b1;
    cyc(3);
    chk("post_rst_fx_valid", {23'b0, fx0.fx_valid}, 24'h0);

    // Bypass path straight to tx
    bypass = 1'b1;
    ad_frame(24'h123456, 24'hFEDCBA);
    chk("byp_no_valid", {23'b0, fx0.fx_valid}, 24'h0);
    da_fall();
    chk("byp_l_tx", l_tx0, 24'h123456);
    chk("byp_r_tx", r_tx0, 24'hFEDCBA);
    chk("byp_l_tx_u1", l_tx1, 24'h123456);
    chk("byp_under", {8'b0, und0}, 24'h0);
    chk("byp_over", {8'b0, ovr0}, 24'h0);

    // Effect path: fx_valid 3 cycles after the sampled fall, stalled by ready
    bypass = 1'b0;
    l_rx = 24'h0ABCDE; r_rx = 24'h7FFFFF; ad_ws = 1'b0;
    cyc(2);
    chk("lat_valid_early", {23'b0, fx0.fx_valid}, 24'h0);
    cyc(1);
    chk("lat_valid_on", {23'b0, fx0.fx_valid}, 24'h1);
    ad_ws = 1'b1;
    cyc(10);
    chk("stall_valid", {23'b0, fx0.fx_valid}, 24'h1);
    chk("stall_l_out", fx0.fx_l_out, 24'h0ABCDE);
    chk("stall_r_out", fx0.fx_r_out, 24'h7FFFFF);
    fx0.fx_ready = 1'b1;
    cyc(1);
    fx0.fx_ready = 1'b0;
    chk("xfer_valid_drop", {23'b0, fx0.fx_valid}, 24'h0);
    // Second frame while waiting on the effect chain is dropped
    ad_frame(24'h444444, 24'h555555);
    chk("ovr_cnt", {8'b0, ovr0}, 24'h1);
    chk("ovr_l_out_kept", fx0.fx_l_out, 24'h0ABCDE);
    fx0.fx_l_in = 24'h000010; fx0.fx_r_in = 24'hFFFFF0; fx0.fx_done = 1'b1;
    cyc(1);
    fx0.fx_done = 1'b0;
    cyc(2);
    da_fall();
    chk("fx_l_tx", l_tx0, 24'h000010);
    chk("fx_r_tx", r_tx0, 24'hFFFFF0);
    chk("fx_under", {8'b0, und0}, 24'h0);

    // Stray done in IDLE is ignored, then three underruns
    fx0.fx_l_in = 24'h555555; fx0.fx_r_in = 24'h666666; fx0.fx_done = 1'b1;
    cyc(1);
    fx0.fx_done = 1'b0;
    cyc(2);
    repeat (3) da_fall();
    chk("und_l_hold", l_tx0, 24'h000010);
    chk("und_r_hold", r_tx0, 24'hFFFFF0);
    chk("und_cnt3", {8'b0, und0}, 24'h3);
    chk("und_l_zero_u1", l_tx1, 24'h0);
    chk("und_cnt3_u1", {20'b0, und1}, 24'h3);

    // Saturation of the 4-bit counter
    repeat (12) da_fall();
    chk("sat_at_max_u1", {20'b0, und1}, 24'hF);
    repeat (2) da_fall();
    chk("sat_hold_u1", {20'b0, und1}, 24'hF);
    chk("no_sat_u0", {8'b0, und0}, 24'h11);

    // Mute commits zeros and clears pending
    bypass = 1'b1;
    ad_frame(24'h111111, 24'h222222);
    mute = 1'b1;
    da_fall();
    chk("mute_l_tx", l_tx0, 24'h0);
    chk("mute_under", {8'b0, und0}, 24'h11);
    mute = 1'b0;
    da_fall();
    chk("mute_cleared_pend", {8'b0, und0}, 24'h12);

    // Newer pair overwrites an uncommitted one
    ad_frame(24'h0A0A0A, 24'h0B0B0B);
    ad_frame(24'h0C0C0C, 24'h0D0D0D);
    da_fall();
    chk("ovw_l_tx", l_tx0, 24'h0C0C0C);
    chk("ovw_r_tx", r_tx0, 24'h0D0D0D);
    chk("ovw_no_ovr", {8'b0, ovr0}, 24'h1);

    // Async reset while offering
    bypass = 1'b0;
    ad_frame(24'h333333, 24'h333333);
    chk("pre_rst_valid", {23'b0, fx0.fx_valid}, 24'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", {23'b0, fx0.fx_valid}, 24'h0);
    chk("arst_l_tx", l_tx0, 24'h0);
    chk("arst_over", {8'b0, ovr0}, 24'h0);
    chk("arst_under", {8'b0, und0}, 24'h0);
    chk("arst_under_u1", {20'b0, und1}, 24'h0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    bypass = 1'b1;
    ad_frame(24'h0F0F0F, 24'h00F00F);
    chk("post_arst_over", {8'b0, ovr0}, 24'h0);
    da_fall();
    chk("post_arst_l_tx", l_tx0, 24'h0F0F0F);
    chk("post_arst_r_tx", r_tx0, 24'h00F00F);
    chk("post_arst_under", {8'b0, und0}, 24'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
